div_arbiter: RTL and testbench

Round-robin scheduler that shares one `div_structural` 32-bit divider among `N_REQ` requesters. Accepts operand pairs over per-requester valid/ready handshakes, sequences the divider's `start`/`ok`/`err` protocol, and returns quotient/remainder to the requester that issued the operation. Sits between client blocks and the single divider instance; the divider never sees more than one operation in flight.

---
 rtl/div_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_div_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// Round-robin front end that shares one iterative divider among N_REQ requesters.
// Optional WAIT-state watchdog is enabled by defining DIV_ARB_TIMEOUT_EN.
module div_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]       rsp_q,
    output logic [WIDTH-1:0]       rsp_r,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   div_start,
    output logic [WIDTH-1:0]       div_a,
    output logic [WIDTH-1:0]       div_b,
    input  logic [WIDTH-1:0]       div_d,
    input  logic [WIDTH-1:0]       div_r,
    input  logic                   div_ok,
    input  logic                   div_err
);

    localparam int IDX_W = $clog2(N_REQ);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
        $error("div_arbiter: unsupported parameter set");
    end

    logic [1:0]       state_r;
    logic [IDX_W-1:0] last_r;
    logic [IDX_W-1:0] owner_r;
    logic             first_wait_r;
    logic             busy_r;
    logic             div_start_r;
    logic [WIDTH-1:0] div_a_r;
    logic [WIDTH-1:0] div_b_r;
    logic [N_REQ-1:0] rsp_valid_r;
    logic [WIDTH-1:0] rsp_q_r;
    logic [WIDTH-1:0] rsp_r_r;
    logic             rsp_err_r;

    logic             grant_found_s;
    logic [IDX_W-1:0] grant_idx_s;
    logic [IDX_W-1:0] cand_s;
    logic [N_REQ-1:0] req_ready_s;
    logic             done_s;
    logic [WIDTH-1:0] a_arr_s [N_REQ];
    logic [WIDTH-1:0] b_arr_s [N_REQ];

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt_r;
    logic            timeout_s;
    assign timeout_s = (wd_cnt_r == WD_W'(TIMEOUT - 1));
`endif

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = {N_REQ{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign a_arr_s[gi] = req_a[gi*WIDTH +: WIDTH];
        assign b_arr_s[gi] = req_b[gi*WIDTH +: WIDTH];
    end

    // Round-robin search starting just past the previous grant, wrapping to 0
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = {IDX_W{1'b0}};
        cand_s        = {IDX_W{1'b0}};
        for (int k = 1; k <= N_REQ; k++) begin
            cand_s = IDX_W'((int'(last_r) + k) % N_REQ);
            if (!grant_found_s && req_valid[cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Accept strobe is combinational so the transfer happens in the grant cycle
    always_comb begin
        req_ready_s = {N_REQ{1'b0}};
        if (state_r == ST_IDLE && grant_found_s && !reset) begin
            req_ready_s = onehot(grant_idx_s);
        end else begin
            req_ready_s = {N_REQ{1'b0}};
        end
    end

    // The first WAIT cycle may still see flags left over from a previous op
    assign done_s = (div_ok | div_err) & ~first_wait_r;

    // Sequencer: operand capture, divider handshake and result registration
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            last_r       <= IDX_W'(N_REQ - 1);
            owner_r      <= {IDX_W{1'b0}};
            first_wait_r <= 1'b0;
            busy_r       <= 1'b0;
            div_start_r  <= 1'b0;
            div_a_r      <= {WIDTH{1'b0}};
            div_b_r      <= {WIDTH{1'b0}};
            rsp_valid_r  <= {N_REQ{1'b0}};
            rsp_q_r      <= {WIDTH{1'b0}};
            rsp_r_r      <= {WIDTH{1'b0}};
            rsp_err_r    <= 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
            wd_cnt_r     <= {WD_W{1'b0}};
`endif
        end else begin
            div_start_r <= 1'b0;
            rsp_valid_r <= {N_REQ{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (grant_found_s) begin
                        owner_r <= grant_idx_s;
                        last_r  <= grant_idx_s;
                        div_a_r <= a_arr_s[grant_idx_s];
                        div_b_r <= b_arr_s[grant_idx_s];
                        busy_r  <= 1'b1;
                        if (b_arr_s[grant_idx_s] == {WIDTH{1'b0}}) begin
                            state_r     <= ST_RESP;
                            rsp_valid_r <= onehot(grant_idx_s);
                            rsp_q_r     <= {WIDTH{1'b0}};
                            rsp_r_r     <= {WIDTH{1'b0}};
                            rsp_err_r   <= 1'b1;
                        end else begin
                            state_r     <= ST_ISSUE;
                            div_start_r <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    state_r      <= ST_WAIT;
                    first_wait_r <= 1'b1;
`ifdef DIV_ARB_TIMEOUT_EN
                    wd_cnt_r     <= {WD_W{1'b0}};
`endif
                end
                ST_WAIT: begin
                    first_wait_r <= 1'b0;
                    if (done_s) begin
                        state_r     <= ST_RESP;
                        rsp_valid_r <= onehot(owner_r);
                        if (div_err) begin
                            rsp_q_r   <= {WIDTH{1'b0}};
                            rsp_r_r   <= {WIDTH{1'b0}};
                            rsp_err_r <= 1'b1;
                        end else begin
                            rsp_q_r   <= div_d;
                            rsp_r_r   <= div_r;
                            rsp_err_r <= 1'b0;
                        end
                    end
`ifdef DIV_ARB_TIMEOUT_EN
                    else if (timeout_s) begin
                        state_r     <= ST_RESP;
                        rsp_valid_r <= onehot(owner_r);
                        rsp_q_r     <= {WIDTH{1'b0}};
                        rsp_r_r     <= {WIDTH{1'b0}};
                        rsp_err_r   <= 1'b1;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + WD_W'(1);
                    end
`endif
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_q     = rsp_q_r;
    assign rsp_r     = rsp_r_r;
    assign rsp_err   = rsp_err_r;
    assign busy      = busy_r;
    assign div_start = div_start_r;
    assign div_a     = div_a_r;
    assign div_b     = div_b_r;

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: transaction-level round-robin/latency model
// plus a behavioural divider with configurable latency, error and hang modes.
module tb_div_arbiter;
    localparam int N   = 4;
    localparam int W   = 32;
    localparam int TMO = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a, req_b;
    logic [N-1:0]   req_ready, rsp_valid;
    logic [W-1:0]   rsp_q, rsp_r, div_a, div_b, div_d, div_r;
    logic           rsp_err, busy, div_start, div_ok, div_err;
    logic           m_ok, m_err, stale_ok;

    always #5 clk = ~clk;
    assign div_ok  = m_ok | stale_ok;
    assign div_err = m_err;

    div_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_q(rsp_q), .rsp_r(rsp_r),
        .rsp_err(rsp_err), .busy(busy), .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_d(div_d), .div_r(div_r), .div_ok(div_ok), .div_err(div_err)
    );

    int n_assert = 0, n_fail = 0, cyc = 0;
    bit pend [N];
    logic [W-1:0] pa [N], pb [N];
    int m_last, m_owner, m_acc, m_lat;
    bit m_busy, m_errexp;
    logic [W-1:0] m_a, m_b;
    int gen_rate = 0, dlat = 1, err_mode = 0;
    bit hang = 1'b0, stale_mode = 1'b0;

    // behavioural divider
    bit dv_pend = 1'b0;
    int dv_cnt = 0;
    logic [W-1:0] dv_a, dv_b;
    initial begin m_ok = 1'b0; m_err = 1'b0; div_d = '0; div_r = '0; end
    always @(negedge clk) begin
        m_ok = 1'b0;
        m_err = 1'b0;
        if (reset) dv_pend = 1'b0;
        else if (div_start) begin
            if (!hang) begin dv_pend = 1'b1; dv_cnt = dlat; dv_a = div_a; dv_b = div_b; end
        end else if (dv_pend) begin
            if (dv_cnt == 0) begin
                dv_pend = 1'b0;
                div_d = dv_a / dv_b;
                div_r = dv_a % dv_b;
                case (err_mode)
                    0: m_ok = 1'b1;
                    1: m_err = 1'b1;
                    default: begin m_ok = 1'b1; m_err = 1'b1; end
                endcase
            end else dv_cnt--;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction

    task automatic new_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        pend[i] = 1'b1; pa[i] = a; pb[i] = b;
    endtask

    function automatic logic [W-1:0] rand_b();
        case ($urandom_range(0, 5))
            0:       return '0;
            1, 2:    return W'($urandom_range(1, 15));
            default: return W'($urandom) >> $urandom_range(0, 31);
        endcase
    endfunction

    // one clock: drive requests, check every output against the model, advance model
    task automatic step();
        logic [N-1:0] exp_rsp;
        int g;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            req_valid[i] = pend[i];
            req_a[i*W +: W] = pa[i];
            req_b[i*W +: W] = pb[i];
        end
        #1;
        cyc++;
        if (stale_ok && cyc == m_acc + 3) stale_ok = 1'b0;
        g = -1;
        if (!m_busy)
            for (int k = 1; k <= N; k++)
                if (g < 0 && pend[(m_last + k) % N]) g = (m_last + k) % N;
        chk("req_ready", 64'(req_ready), (g >= 0) ? 64'(oh(g)) : 64'd0);
        chk("busy", 64'(busy), 64'(m_busy));
        chk("div_start", 64'(div_start), 64'(m_busy && m_b != 0 && cyc == m_acc + 1));
        if (m_busy && m_b != 0 && cyc == m_acc + 1) begin
            chk("div_a", 64'(div_a), 64'(m_a));
            chk("div_b", 64'(div_b), 64'(m_b));
        end
        exp_rsp = (m_busy && cyc == m_acc + m_lat) ? oh(m_owner) : '0;
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
        if (exp_rsp != '0) begin
            chk("rsp_err", 64'(rsp_err), 64'(m_errexp));
            chk("rsp_q", 64'(rsp_q), m_errexp ? 64'd0 : 64'(m_a / m_b));
            chk("rsp_r", 64'(rsp_r), m_errexp ? 64'd0 : 64'(m_a % m_b));
            m_busy = 1'b0;
        end
        if (g >= 0) begin
            m_busy = 1'b1; m_owner = g; m_a = pa[g]; m_b = pb[g];
            m_acc = cyc; m_last = g; pend[g] = 1'b0;
            if (m_b == 0) begin
                m_lat = 1; m_errexp = 1'b1;
            end else begin
                dlat = stale_mode ? $urandom_range(2, 5) : $urandom_range(1, 5);
                m_lat = dlat + 3;
                m_errexp = (err_mode != 0);
                if (stale_mode) stale_ok = 1'b1;
                if (hang) begin
`ifdef DIV_ARB_TIMEOUT_EN
                    m_lat = TMO + 2; m_errexp = 1'b1;
`else
                    m_lat = 1000000;
`endif
                end
            end
        end
        for (int i = 0; i < N; i++)
            if (!pend[i] && $urandom_range(0, 99) < gen_rate) new_op(i, W'($urandom), rand_b());
    endtask

    task automatic reset_cycle();
        reset = 1'b1;
        @(negedge clk);
        #1;
        cyc++;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_div_start", 64'(div_start), 64'd0);
        chk("rst_rsp_q", 64'(rsp_q), 64'd0);
        chk("rst_rsp_r", 64'(rsp_r), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_div_ab", {32'(div_a), 32'(div_b)}, 64'd0);
        reset = 1'b0;
        m_busy = 1'b0; m_last = N - 1; stale_ok = 1'b0;
    endtask

    task automatic drain();
        bit any;
        gen_rate = 0;
        any = 1'b1;
        for (int k = 0; k < 600 && any; k++) begin
            step();
            any = m_busy;
            for (int i = 0; i < N; i++) any = any | pend[i];
        end
        chk("drain_timeout", 64'(any), 64'd0);
    endtask

    initial begin
        reset = 1'b1; stale_ok = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0;
        for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; end
        m_busy = 1'b0; m_last = N - 1; m_acc = 0; m_lat = 0; m_b = '0; m_a = '0;
        reset_cycle();
        reset_cycle();

        new_op(1, 32'd1023, 32'd50);
        drain();

        for (int i = 0; i < N; i++) new_op(i, W'($urandom), W'($urandom_range(1, 1000)));
        drain();
        gen_rate = 100;
        for (int k = 0; k < 60; k++) step();
        drain();

        new_op(2, W'($urandom), 32'd0);
        drain();

        for (int m = 1; m <= 2; m++) begin
            err_mode = m;
            for (int i = 0; i < 3; i++) new_op(i, W'($urandom), W'($urandom_range(1, 99)));
            drain();
        end
        err_mode = 0;

        stale_mode = 1'b1;
        new_op(0, 32'd77777, 32'd13);
        drain();
        new_op(3, W'($urandom), W'($urandom_range(1, 9)));
        drain();
        stale_mode = 1'b0;

        new_op(3, 32'd100, 32'd7);
        for (int k = 0; k < 20 && !(m_busy && cyc == m_acc + 2); k++) step();
        chk("reached_wait", 64'(m_busy && cyc == m_acc + 2), 64'd1);
        reset_cycle();
        new_op(0, 32'd5000, 32'd9);
        drain();

        gen_rate = 30;
        for (int k = 0; k < 400; k++) step();
        drain();

        hang = 1'b1;
        new_op(1, 32'd42, 32'd5);
`ifdef DIV_ARB_TIMEOUT_EN
        drain();
`else
        for (int k = 0; k < 100; k++) step();
        chk("hang_busy", 64'(busy), 64'd1);
        reset_cycle();
`endif
        hang = 1'b0;
        new_op(2, 32'd999, 32'd10);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
